// File: rtl/tail_light_sequencer_pkg.sv
// rtl/tail_light_sequencer_pkg.sv - shared types and defaults for the tail light sequencer
package tail_light_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1,
    ST_L2,
    ST_L3,
    ST_R1,
    ST_R2,
    ST_R3,
    ST_HAZ
  } state_t;

  // Bit 0 is the inner lamp (a), bit 2 the outer lamp (c).
  typedef logic [2:0] lamp_mask_t;

  localparam logic [7:0] DIM_DUTY_DEFAULT  = 8'd32;
  localparam logic [7:0] FULL_DUTY_DEFAULT = 8'd255;

  // Left-side lamps lit in a given state.
  function automatic lamp_mask_t left_mask(input state_t s);
    case (s)
      ST_L1:   return 3'b001;
      ST_L2:   return 3'b011;
      ST_L3:   return 3'b111;
      ST_HAZ:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Right-side lamps lit in a given state.
  function automatic lamp_mask_t right_mask(input state_t s);
    case (s)
      ST_R1:   return 3'b001;
      ST_R2:   return 3'b011;
      ST_R3:   return 3'b111;
      ST_HAZ:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tail_light_sequencer_duty_ramp.sv
// rtl/tail_light_sequencer_duty_ramp.sv - saturating duty ramp for one lamp
module duty_ramp #(
  parameter logic [7:0] FADE_STEP = 8'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fade_tick,
  input  logic [7:0] target,
  output logic [7:0] duty
);

  logic [7:0] gap;

  // Distance to target; the subtraction order keeps it non-negative.
  always_comb begin
    gap = (target >= duty) ? (target - duty) : (duty - target);
  end

  // Step toward target on each fade tick; land exactly when within one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= 8'd0;
    end else if (fade_tick) begin
      if (gap <= FADE_STEP) begin
        duty <= target;
      end else if (target > duty) begin
        duty <= duty + FADE_STEP;
      end else begin
        duty <= duty - FADE_STEP;
      end
    end
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// rtl/tail_light_sequencer.sv - sequential turn/hazard tail light controller with fading
module tail_light_sequencer
  import tail_light_sequencer_pkg::*;
#(
  parameter logic [23:0] TICK_DIV  = 24'd6000000,
  parameter logic [15:0] FADE_DIV  = 16'd20000,
  parameter logic [7:0]  FADE_STEP = 8'd8,
  parameter logic [7:0]  DIM_DUTY  = DIM_DUTY_DEFAULT,
  parameter logic [7:0]  FULL_DUTY = FULL_DUTY_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  output logic [7:0] duty_la,
  output logic [7:0] duty_lb,
  output logic [7:0] duty_lc,
  output logic [7:0] duty_ra,
  output logic [7:0] duty_rb,
  output logic [7:0] duty_rc,
  output logic       busy
);

  state_t      state_q;
  state_t      state_d;
  logic [23:0] step_cnt;
  logic [15:0] fade_cnt;
  logic        step_tick;
  logic        fade_tick;
  logic        idle_exit;
  logic [5:0]  lit;
  logic [7:0]  duty [6];

  assign step_tick = (step_cnt == TICK_DIV - 24'd1);
  assign fade_tick = (fade_cnt == FADE_DIV - 16'd1);
  assign idle_exit = (state_q == ST_IDLE) && (state_d != ST_IDLE);

  // Step prescaler; restarted on leaving IDLE so every step lasts TICK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= 24'd0;
    end else if (idle_exit || step_tick) begin
      step_cnt <= 24'd0;
    end else begin
      step_cnt <= step_cnt + 24'd1;
    end
  end

  // Free-running fade prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fade_cnt <= 16'd0;
    end else if (fade_tick) begin
      fade_cnt <= 16'd0;
    end else begin
      fade_cnt <= fade_cnt + 16'd1;
    end
  end

  // Next state: requests are only sampled in IDLE; sequences always run to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hazard || (left && right)) state_d = ST_HAZ;
        else if (left)                 state_d = ST_L1;
        else if (right)                state_d = ST_R1;
      end
      ST_L1:   if (step_tick) state_d = ST_L2;
      ST_L2:   if (step_tick) state_d = ST_L3;
      ST_L3:   if (step_tick) state_d = ST_IDLE;
      ST_R1:   if (step_tick) state_d = ST_R2;
      ST_R2:   if (step_tick) state_d = ST_R3;
      ST_R3:   if (step_tick) state_d = ST_IDLE;
      ST_HAZ:  if (step_tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with busy tracking the new state on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
    end
  end

  // Lamp pattern of the current state: bits 2:0 left, 5:3 right.
  always_comb begin
    lit = {right_mask(state_q), left_mask(state_q)};
  end

  genvar i;
  for (i = 0; i < 6; i++) begin : g_lamp
    duty_ramp #(
      .FADE_STEP(FADE_STEP)
    ) u_ramp (
      .clk       (clk),
      .rst_n     (rst_n),
      .fade_tick (fade_tick),
      .target    (lit[i] ? FULL_DUTY : DIM_DUTY),
      .duty      (duty[i])
    );
  end

  assign duty_la = duty[0];
  assign duty_lb = duty[1];
  assign duty_lc = duty[2];
  assign duty_ra = duty[3];
  assign duty_rb = duty[4];
  assign duty_rc = duty[5];

endmodule

// File: tb/tb_tail_light_sequencer.sv
// tb/tb_tail_light_sequencer.sv - scoreboard bench for the tail light sequencer
module tb_tail_light_sequencer;

  localparam int N = 3;

  // Per-instance configuration mirrored by the reference model.
  int td   [N] = '{4, 4, 5};
  int fd   [N] = '{1, 1, 3};
  int fs   [N] = '{255, 16, 16};
  int dim  [N] = '{32, 32, 40};
  int full [N] = '{255, 255, 200};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic left = 1'b0;
  logic right = 1'b0;
  logic hazard = 1'b0;

  logic [7:0] a_la, a_lb, a_lc, a_ra, a_rb, a_rc;
  logic [7:0] b_la, b_lb, b_lc, b_ra, b_rb, b_rc;
  logic [7:0] c_la, c_lb, c_lc, c_ra, c_rb, c_rc;
  logic       a_busy, b_busy, c_busy;
  logic [48:0] obs [N];

  typedef logic [N-1:0][48:0] exp_t;
  exp_t exp_q [$];

  int checks = 0;
  int errors = 0;
  int mon_cycle = 0;

  // Reference model: active sequence kind (0 none, 1 left, 2 right, 3 hazard),
  // cycles elapsed in it, fade prescaler phase and lamp duties.
  int kind   [N];
  int t_seq  [N];
  int fcnt   [N];
  int duty_m [N][6];

  always #5 clk = ~clk;

  tail_light_sequencer #(
    .TICK_DIV(24'd4), .FADE_DIV(16'd1), .FADE_STEP(8'd255), .DIM_DUTY(8'd32), .FULL_DUTY(8'd255)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .hazard(hazard),
    .duty_la(a_la), .duty_lb(a_lb), .duty_lc(a_lc),
    .duty_ra(a_ra), .duty_rb(a_rb), .duty_rc(a_rc), .busy(a_busy)
  );

  tail_light_sequencer #(
    .TICK_DIV(24'd4), .FADE_DIV(16'd1), .FADE_STEP(8'd16), .DIM_DUTY(8'd32), .FULL_DUTY(8'd255)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .hazard(hazard),
    .duty_la(b_la), .duty_lb(b_lb), .duty_lc(b_lc),
    .duty_ra(b_ra), .duty_rb(b_rb), .duty_rc(b_rc), .busy(b_busy)
  );

  tail_light_sequencer #(
    .TICK_DIV(24'd5), .FADE_DIV(16'd3), .FADE_STEP(8'd16), .DIM_DUTY(8'd40), .FULL_DUTY(8'd200)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .hazard(hazard),
    .duty_la(c_la), .duty_lb(c_lb), .duty_lc(c_lc),
    .duty_ra(c_ra), .duty_rb(c_rb), .duty_rc(c_rc), .busy(c_busy)
  );

  assign obs[0] = {a_busy, a_rc, a_rb, a_ra, a_lc, a_lb, a_la};
  assign obs[1] = {b_busy, b_rc, b_rb, b_ra, b_lc, b_lb, b_la};
  assign obs[2] = {c_busy, c_rc, c_rb, c_ra, c_lc, c_lb, c_la};

  function automatic logic [48:0] pack(input int i);
    logic [48:0] v;
    v[48] = (kind[i] != 0);
    for (int j = 0; j < 6; j++) v[j*8 +: 8] = 8'(duty_m[i][j]);
    return v;
  endfunction

  // Advance the model across one rising edge with the given inputs held.
  task automatic model_step(input logic l, input logic r, input logic h, input logic rst);
    int   n;
    int   tgt;
    int   diff;
    bit   lit;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        kind[i] = 0;
        t_seq[i] = 0;
        fcnt[i] = 0;
        for (int j = 0; j < 6; j++) duty_m[i][j] = 0;
      end else begin
        // Lamps lit: one more per elapsed step of TICK_DIV cycles.
        n = (kind[i] != 0) ? (t_seq[i] / td[i] + 1) : 0;
        for (int j = 0; j < 6; j++) begin
          lit = (kind[i] == 3) || (kind[i] == 1 && j < 3 && j < n) ||
                (kind[i] == 2 && j >= 3 && (j - 3) < n);
          tgt = lit ? full[i] : dim[i];
          if (fcnt[i] == fd[i] - 1) begin
            diff = tgt - duty_m[i][j];
            if (diff >= -fs[i] && diff <= fs[i]) duty_m[i][j] = tgt;
            else if (diff > 0)                    duty_m[i][j] += fs[i];
            else                                  duty_m[i][j] -= fs[i];
          end
        end
        fcnt[i] = (fcnt[i] == fd[i] - 1) ? 0 : fcnt[i] + 1;
        if (kind[i] == 0) begin
          kind[i] = (h || (l && r)) ? 3 : l ? 1 : r ? 2 : 0;
          t_seq[i] = 0;
        end else begin
          t_seq[i]++;
          if (t_seq[i] == ((kind[i] == 3) ? 1 : 3) * td[i]) begin
            kind[i] = 0;
            t_seq[i] = 0;
          end
        end
      end
      e[i] = pack(i);
    end
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus just after the falling edge and predict the next edge.
  task automatic cycle(input logic l, input logic r, input logic h, input logic rst);
    @(negedge clk);
    #1;
    rst_n  = rst;
    left   = l;
    right  = r;
    hazard = h;
    model_step(l, r, h, rst);
  endtask

  task automatic run(input int cnt, input logic l, input logic r, input logic h);
    for (int k = 0; k < cnt; k++) cycle(l, r, h, 1'b1);
  endtask

  // Monitor: every falling edge compares DUT outputs with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_cycle++;
        for (int i = 0; i < N; i++) begin
          checks++;
          if (obs[i] !== e[i]) begin
            errors++;
            $display("FAIL scoreboard inst %0d cycle %0d: got %h expected %h", i, mon_cycle, obs[i], e[i]);
          end
        end
      end
    end
  end

  initial begin
    // Reset, then settle to dim.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run(12, 1'b0, 1'b0, 1'b0);
    // Held left: repeated left sequences.
    run(40, 1'b1, 1'b0, 1'b0);
    run(16, 1'b0, 1'b0, 1'b0);
    // One-cycle left+right pulse and hazard pulse.
    run(1, 1'b1, 1'b1, 1'b0);
    run(16, 1'b0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 1'b1);
    run(16, 1'b0, 1'b0, 1'b0);
    // Right raised during L2 and held past the end of the left sequence.
    run(1, 1'b1, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0);
    run(10, 1'b0, 1'b1, 1'b0);
    run(20, 1'b0, 1'b0, 1'b0);
    // Right pulsed only during L2.
    run(1, 1'b1, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);
    run(20, 1'b0, 1'b0, 1'b0);
    // Reset asserted between edges while in L3.
    run(1, 1'b1, 1'b0, 1'b0);
    run(8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs[i] !== 49'd0) begin
        errors++;
        $display("FAIL async_reset inst %0d: got %h expected 0", i, obs[i]);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run(20, 1'b0, 1'b0, 1'b0);
    // Randomized requests with occasional resets.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) != 0));
    end
    run(20, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tail_light_sequencer.md
TAIL_LIGHT_SEQUENCER -- requirements
Module: tail_light_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 24'd6000000, clock cycles per sequence step; legal range >= 2.
REQ-002 Parameter FADE_DIV, default 16'd20000, clock cycles per fade update; legal range >= 1.
REQ-003 Parameter FADE_STEP, default 8'd8, duty change per fade update; legal range 1..255.
REQ-004 Parameter DIM_DUTY, default 8'd32, duty value for an unlit lamp.
REQ-005 Parameter FULL_DUTY, default 8'd255, duty value for a lit lamp; must exceed DIM_DUTY.
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 left  input  1  left-turn request, level, already synchronous to clk.
REQ-009 right  input  1  right-turn request, level, already synchronous to clk.
REQ-010 hazard  input  1  hazard request, level, already synchronous to clk.
REQ-011 duty_la, duty_lb, duty_lc  output  8 each  left lamp duty cycles, inner to outer; each drives one PWM stage.
REQ-012 duty_ra, duty_rb, duty_rc  output  8 each  right lamp duty cycles, inner to outer.
REQ-013 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-014 Step prescaler counts 0..TICK_DIV-1 and wraps to 0; step_tick asserts for the one cycle in which count == TICK_DIV-1.
REQ-015 Prescaler is cleared to 0 on every IDLE exit, so the first step_tick occurs exactly TICK_DIV cycles after that exit.
REQ-016 FSM states: IDLE, L1, L2, L3, R1, R2, R3, HAZ.
REQ-017 From IDLE, on the next edge: hazard=1 or (left=1 and right=1) -> HAZ; else left=1 -> L1; else right=1 -> R1; else remain in IDLE.
REQ-018 L1->L2->L3->IDLE and R1->R2->R3->IDLE, each transition on step_tick only; HAZ->IDLE on step_tick.
REQ-019 Request inputs are ignored outside IDLE; a sequence always completes, and a held request restarts it from IDLE on the next edge.
REQ-020 Lit lamps: L1={la}, L2={la,lb}, L3={la,lb,lc}, R1..R3 analogous on the right side, HAZ=all six, IDLE=none.
REQ-021 Per-lamp target = FULL_DUTY if lit, else DIM_DUTY.
REQ-022 Fade prescaler counts 0..FADE_DIV-1 and free-runs; fade_tick asserts when count == FADE_DIV-1 (FADE_DIV=1 gives fade_tick every cycle).
REQ-023 On fade_tick, each duty output moves toward its target by FADE_STEP; if |target-duty| <= FADE_STEP, it loads target exactly; no overflow or underflow past the target.
REQ-024 Between fade_ticks, duty outputs hold their values; a target change mid-fade redirects the ramp from the current value.
REQ-025 Duty outputs are registered; a target change is first visible on an output at the first fade_tick after the FSM state update.
REQ-026 busy is the registered value (state != IDLE).

Reset
REQ-027 rst_n low immediately forces state=IDLE, both prescalers=0, all duty outputs=8'd0, and busy=0, including in the middle of a sequence.
REQ-028 After reset release, duty outputs ramp from 0 to DIM_DUTY under REQ-023.

Structure
REQ-029 A shared package holds the FSM state enumeration, the 3-bit lamp-mask typedef, and the DIM_DUTY and FULL_DUTY defaults.
REQ-030 One sub-module, duty_ramp, is instantiated six times; it contains one lamp's saturating ramp register (inputs: fade_tick, target; output: duty).
REQ-031 The FSM and both prescalers reside in the top module.

Verification
REQ-032 Parameters: TICK_DIV=4, FADE_DIV=1, FADE_STEP=255 unless stated.
REQ-033 Hold left=1 for the full run -> busy rises 1 cycle later; duty_la=255 while duty_lb/lc=32; every 4 cycles the pattern advances L1->L2->L3->IDLE; all left lamps return to 32; the sequence restarts; right lamps stay at 32 throughout.
REQ-034 Pulse left=1 and right=1 for 1 cycle -> HAZ for 4 cycles with all six outputs at 255, then IDLE with all outputs at 32.
REQ-035 Assert right during L2 -> no effect until IDLE; R1 entered on the next edge after IDLE only if right is still high.
REQ-036 Set FADE_STEP=16 and request left from settled IDLE -> duty_la follows 32, 48, ..., 240, 255 (one step per cycle) and ends exactly at 255 without overshoot; the reverse ramp ends exactly at 32.
REQ-037 Drop rst_n in L3 -> all outputs read 0 and busy reads 0 before the next clock edge; after release, outputs ramp to 32 and the FSM stays in IDLE with no requests.
